// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder sequencer. It drives one external combinational 1-bit
//   full adder LSB first, keeps the carry in a register between bits, and
//   builds the WIDTH-bit sum. A single result {cout, sum} = op_a + op_b + cin
//   is produced every WIDTH+1 cycles.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               request; sampled only in IDLE or DONE
//   op_a, op_b, cin     operands and initial carry, captured on accepted start
//   busy                high while bits are being shifted
//   done                one-cycle completion strobe
//   sum, cout           registered result; held until the next completion
//   fa_a, fa_b, fa_cin  to the full adder's A0, A1 and A2 pins
//   fa_s, fa_co         from the full adder's B0 (sum) and B1 (carry) pins

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_co
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    // The adder sees live bits only in SHIFT. Everywhere else it is held at
    // zero, so a reset clears these pins together with the state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        if (state == SHIFT) begin
            fa_a   = sa[0];
            fa_b   = sb[0];
            fa_cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register then samples its pre-edge value, so statement order inside
        // this block does not matter.
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                // DONE accepts start just like IDLE does. This is what gives
                // back-to-back operation.
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= op_a;
                        sb    <= op_b;
                        carry <= cin;
                        cnt   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                SHIFT: begin
                    // Sum bits enter at the MSB and move down. After WIDTH
                    // edges, bit 0 of the result sits at acc[0].
                    acc   <= {fa_s, acc[WIDTH-1:1]};
                    carry <= fa_co;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // Update the visible result only here, so it stays
                        // stable while a later operation is in progress.
                        sum   <= {fa_s, acc[WIDTH-1:1]};
                        cout  <= fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Directed bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder
//   attached. Each scenario task compares the DUT against values worked out by
//   hand or taken from plain integer addition.

module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] op_a  = '0;
    logic [WIDTH-1:0] op_b  = '0;
    logic             cin   = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_co;

    int vectors     = 0;
    int miscompares = 0;

    serial_add_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .fa_a   (fa_a),
        .fa_b   (fa_b),
        .fa_cin (fa_cin),
        .fa_s   (fa_s),
        .fa_co  (fa_co)
    );

    // Behavioural model of the combinational full-adder cell.
    assign fa_s  = fa_a ^ fa_b ^ fa_cin;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    // Hard stop in case the bench itself gets stuck.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one operation. Outputs are sampled on falling edges. The edge that
    // accepts start is counted as edge 1, so done should be seen after edge
    // WIDTH+1. While busy, the adder pins are checked against the true bits
    // and the true carry into bit k.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, output logic [WIDTH-1:0] s,
                         output logic co, output int edges, output int busy_cyc,
                         output int path_err);
        int k;
        int msk;
        int t;
        s        = '0;
        co       = 1'b0;
        edges    = 0;
        busy_cyc = 0;
        path_err = 0;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) begin
                busy_cyc++;
                k = edges - 1;
                if (k < WIDTH) begin
                    msk = (1 << k) - 1;
                    t   = (int'(a) & msk) + (int'(b) & msk) + int'(c);
                    if (fa_a !== a[k] || fa_b !== b[k] || fa_cin !== t[k])
                        path_err++;
                end else begin
                    path_err++;
                end
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        s  = sum;
        co = cout;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({busy, done, cout} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: busy/done/cout=%b expected 000", {busy, done, cout});
        end
        vectors++;
        if (sum !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_sum: got %h expected 00", sum);
        end
        vectors++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_fa: got %b expected 000", {fa_a, fa_b, fa_cin});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, fa_a, fa_b, fa_cin} !== 5'b00000) begin
            miscompares++;
            $display("FAIL idle_outputs: got %b expected 00000", {busy, done, fa_a, fa_b, fa_cin});
        end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] s;
        logic co;
        int e, bc, pe;
        do_op(8'h5A, 8'h33, 1'b0, s, co, e, bc, pe);
        vectors++;
        if ({co, s} !== 9'h08D) begin
            miscompares++;
            $display("FAIL basic_result: got %h expected 08d", {co, s});
        end
        vectors++;
        if (e !== 9) begin
            miscompares++;
            $display("FAIL basic_latency: done after %0d edges expected 9", e);
        end
        vectors++;
        if (bc !== 8) begin
            miscompares++;
            $display("FAIL basic_busy: busy for %0d cycles expected 8", bc);
        end
        vectors++;
        if (pe !== 0) begin
            miscompares++;
            $display("FAIL basic_fa_pins: %0d bad cycles expected 0", pe);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy_in_done: got %b expected 0", busy);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_width: done still %b expected 0", done);
        end
    endtask

    task automatic test_carry();
        logic [WIDTH-1:0] s;
        logic co;
        int e, bc, pe;
        do_op(8'hFF, 8'h01, 1'b0, s, co, e, bc, pe);
        vectors++;
        if ({co, s} !== 9'h100) begin
            miscompares++;
            $display("FAIL carry_ff_01: got %h expected 100", {co, s});
        end
        do_op(8'hFF, 8'hFF, 1'b1, s, co, e, bc, pe);
        vectors++;
        if ({co, s} !== 9'h1FF) begin
            miscompares++;
            $display("FAIL carry_ff_ff_1: got %h expected 1ff", {co, s});
        end
        vectors++;
        if (pe !== 0) begin
            miscompares++;
            $display("FAIL carry_fa_pins: %0d bad cycles expected 0", pe);
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        logic [WIDTH:0] res = '0;
        @(negedge clk);
        op_a  = 8'h10;
        op_b  = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        op_a  = 8'hAA;
        op_b  = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                dones++;
                res = {cout, sum};
            end
            @(negedge clk);
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL ignored_done_count: got %0d expected 1", dones);
        end
        vectors++;
        if (res !== 9'h030) begin
            miscompares++;
            $display("FAIL ignored_result: got %h expected 030", res);
        end
    endtask

    task automatic test_back_to_back();
        int e1 = 1;
        int e2 = 1;
        int stable_err = 0;
        @(negedge clk);
        op_a  = 8'h21;
        op_b  = 8'h13;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Start stays high: ignored during SHIFT, accepted in DONE.
        op_a = 8'h01;
        op_b = 8'h01;
        while (done !== 1'b1 && e1 < 40) begin
            @(posedge clk);
            e1++;
            @(negedge clk);
        end
        vectors++;
        if (e1 !== 9) begin
            miscompares++;
            $display("FAIL b2b_first_latency: %0d edges expected 9", e1);
        end
        vectors++;
        if ({cout, sum} !== 9'h034) begin
            miscompares++;
            $display("FAIL b2b_first_result: got %h expected 034", {cout, sum});
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && e2 < 40) begin
            if ({cout, sum} !== 9'h034) stable_err++;
            @(posedge clk);
            e2++;
            @(negedge clk);
        end
        vectors++;
        if (e2 !== 9) begin
            miscompares++;
            $display("FAIL b2b_spacing: second done %0d edges after first expected 9", e2);
        end
        vectors++;
        if (stable_err !== 0) begin
            miscompares++;
            $display("FAIL b2b_sum_hold: %0d cycles with sum changed expected 0", stable_err);
        end
        vectors++;
        if ({cout, sum} !== 9'h002) begin
            miscompares++;
            $display("FAIL b2b_second_result: got %h expected 002", {cout, sum});
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] s;
        logic co;
        int e, bc, pe;
        @(negedge clk);
        op_a  = 8'h5A;
        op_b  = 8'h33;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, cout} !== 3'b000) begin
            miscompares++;
            $display("FAIL midreset_flags: busy/done/cout=%b expected 000", {busy, done, cout});
        end
        vectors++;
        if (sum !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_sum: got %h expected 00", sum);
        end
        vectors++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            miscompares++;
            $display("FAIL midreset_fa: got %b expected 000", {fa_a, fa_b, fa_cin});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h0F, 8'hF1, 1'b0, s, co, e, bc, pe);
        vectors++;
        if ({co, s} !== 9'h100) begin
            miscompares++;
            $display("FAIL midreset_fresh: got %h expected 100", {co, s});
        end
        vectors++;
        if (e !== 9) begin
            miscompares++;
            $display("FAIL midreset_latency: %0d edges expected 9", e);
        end
    endtask

    task automatic test_sweep();
        logic [WIDTH-1:0] a, b, s;
        logic c, co;
        logic [WIDTH:0] expv;
        int e, bc, pe;
        for (int i = 0; i < 1000; i++) begin
            a    = WIDTH'($urandom);
            b    = WIDTH'($urandom);
            c    = 1'($urandom);
            expv = {1'b0, a} + {1'b0, b} + {8'h00, c};
            do_op(a, b, c, s, co, e, bc, pe);
            vectors++;
            if ({co, s} !== expv || e !== 9 || pe !== 0) begin
                miscompares++;
                $display("FAIL sweep %0d: %h+%h+%b got %h edges %0d pin_err %0d expected %h edges 9 pin_err 0",
                         i, a, b, c, {co, s}, e, pe, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
